// File: rtl/booth_mult_scheduler.sv
// Round-robin scheduler sharing one radix-4 Booth multiplier among NUM_REQ requesters.
// Sequences the multiplier reset/counter and returns each product tagged with its requester ID.
module booth_mult_scheduler #(
  parameter int NUM_REQ      = 3,
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 12,
  parameter int COUNTER_SIZE = 3,
  parameter int DONE_COUNT   = 4,
  parameter int ID_WIDTH     = 2
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [NUM_REQ-1:0]               req_valid_in,
  output logic [NUM_REQ-1:0]               req_ready_out,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0]   multiplicand_in,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0]   multiplier_in,
  output logic                             mult_rst_out,
  output logic [INPUT_WIDTH-1:0]           mult_multiplicand_out,
  output logic [INPUT_WIDTH-1:0]           mult_multiplier_out,
  input  logic [OUTPUT_WIDTH-1:0]          mult_product_in,
  input  logic [COUNTER_SIZE-1:0]          mult_counter_in,
  output logic                             resp_valid_out,
  input  logic                             resp_ready_in,
  output logic [OUTPUT_WIDTH-1:0]          resp_product_out,
  output logic [ID_WIDTH-1:0]              resp_id_out,
  output logic                             busy_out
);

  // state  | meaning
  // IDLE   | multiplier held in reset, arbitrating requests
  // LOAD   | one cycle with reset held so the multiplier captures operands
  // RUN    | multiplier iterating, waiting for counter == DONE_COUNT
  // RESP   | product presented on the response channel until accepted
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_t;

  localparam logic [ID_WIDTH:0]       L_NUM_REQ  = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0]     L_PTR_INIT = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [COUNTER_SIZE-1:0] L_DONE     = COUNTER_SIZE'(DONE_COUNT);

  state_t                  r_state;
  logic [ID_WIDTH-1:0]     r_rr_ptr;
  logic                    r_mult_rst;
  logic [INPUT_WIDTH-1:0]  r_mcand;
  logic [INPUT_WIDTH-1:0]  r_mplier;
  logic [OUTPUT_WIDTH-1:0] r_prod;
  logic [ID_WIDTH-1:0]     r_id;
  logic                    r_resp_valid;
  logic                    r_busy;

  logic                    w_grant_vld;
  logic [ID_WIDTH-1:0]     w_grant_idx;
  logic [ID_WIDTH:0]       w_idx_ext;
  logic [ID_WIDTH-1:0]     w_idx;
  logic [INPUT_WIDTH-1:0]  w_sel_mcand;
  logic [INPUT_WIDTH-1:0]  w_sel_mplier;

  // Scan from farthest to nearest after the pointer so the nearest valid requester wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_idx_ext   = '0;
    w_idx       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx_ext = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(k);
      if (w_idx_ext >= L_NUM_REQ) w_idx_ext = w_idx_ext - L_NUM_REQ;
      w_idx = w_idx_ext[ID_WIDTH-1:0];
      if (req_valid_in[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_mcand   = '0;
    w_sel_mplier  = '0;
    req_ready_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == ID_WIDTH'(i)) begin
        w_sel_mcand  = multiplicand_in[i*INPUT_WIDTH +: INPUT_WIDTH];
        w_sel_mplier = multiplier_in[i*INPUT_WIDTH +: INPUT_WIDTH];
      end
      req_ready_out[i] = (r_state == S_IDLE) && w_grant_vld && (w_grant_idx == ID_WIDTH'(i));
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= L_PTR_INIT;
      r_mult_rst   <= 1'b1;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_prod       <= '0;
      r_id         <= '0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mult_rst <= 1'b1;
          if (w_grant_vld) begin
            r_mcand  <= w_sel_mcand;
            r_mplier <= w_sel_mplier;
            r_id     <= w_grant_idx;
            r_rr_ptr <= w_grant_idx;
            r_busy   <= 1'b1;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_mult_rst <= 1'b0;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          if (mult_counter_in == L_DONE) begin
            r_prod       <= mult_product_in;
            r_resp_valid <= 1'b1;
            r_mult_rst   <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready_in) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mult_rst_out          = r_mult_rst;
  assign mult_multiplicand_out = r_mcand;
  assign mult_multiplier_out   = r_mplier;
  assign resp_valid_out        = r_resp_valid;
  assign resp_product_out      = r_prod;
  assign resp_id_out           = r_id;
  assign busy_out              = r_busy;

endmodule
